// File: rtl/timer_share_arb_if.sv
// Request/grant bundle between requesters and the shared-timer arbiter.
// The master side drives requests, lengths and abort; the slave side returns ownership and count.
interface timer_share_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic                   abort;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [CNT_W-1:0]       count;

  modport master (
    output req, len, abort,
    input  gnt, done, busy, count
  );

  modport slave (
    input  req, len, abort,
    output gnt, done, busy, count
  );
endinterface

// File: rtl/timer_share_arb.sv
// Round-robin owner of one shared up-counter. It grants one requester at a time, counts from 0 to
// that requester's latched length, then pulses its done flag.
module timer_share_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  timer_share_arb_if.slave bus
);
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [IdxW-1:0]   last_q, last_d;

  logic              found;
  logic [IdxW-1:0]   win;
  logic [IdxW:0]     cand_sum;
  logic [IdxW-1:0]   cand;

  // Search upward from last_q+1, wrapping; the first hit in that order wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_sum = {1'b0, last_q} + (IdxW+1)'(k);
      if (cand_sum >= (IdxW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IdxW+1)'(N_REQ);
      end
      cand = cand_sum[IdxW-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    count_d  = count_q;
    target_d = target_q;
    last_d   = last_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StRun;
          gnt_d    = '0;
          gnt_d[win] = 1'b1;
          busy_d   = 1'b1;
          count_d  = '0;
          target_d = bus.len[win*CNT_W +: CNT_W];
          last_d   = win;
        end
      end
      StRun: begin
        // Cancel beats completion when both happen in the same cycle.
        if (bus.abort || !bus.req[last_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (count_q == target_q) begin
          state_d = StDone;
          done_d  = gnt_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      target_q <= '0;
      last_q   <= IdxW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      target_q <= target_d;
      last_q   <= last_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_timer_share_arb.sv
// Bench for timer_share_arb: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model (owner, elapsed cycles, target).
module tb_timer_share_arb;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timer_share_arb_if #(.N_REQ(NR), .CNT_W(CW)) bus ();

  timer_share_arb #(.N_REQ(NR), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner plus cycles elapsed since grant. Elapsed 0..tgt is counting, tgt+1 is completion.
  bit m_busy;
  int m_owner, m_k, m_tgt, m_last;

  always @(posedge clk or posedge rst) begin : model
    bit b;
    int o, k, t, l;
    if (rst) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_k     <= 0;
      m_tgt   <= 0;
      m_last  <= NR - 1;
    end else begin
      b = m_busy; o = m_owner; k = m_k; t = m_tgt; l = m_last;
      if (!b) begin
        for (int i = 1; i <= NR; i++) begin
          int c;
          c = (l + i) % NR;
          if (!b && bus.req[c]) begin
            b = 1'b1; o = c; k = 0; t = int'(bus.len[c*CW +: CW]);
          end
        end
        if (b) l = o;
      end else if (k <= t) begin
        if (bus.abort || !bus.req[o]) b = 1'b0;
        else k++;
      end else begin
        b = 1'b0;
      end
      m_busy <= b; m_owner <= o; m_k <= k; m_tgt <= t; m_last <= l;
    end
  end

  always @(negedge clk) begin : compare
    logic [NR-1:0] eg, ed;
    logic [CW-1:0] ec;
    eg = '0; ed = '0; ec = '0;
    if (m_busy) begin
      eg[m_owner] = 1'b1;
      ec = CW'((m_k < m_tgt) ? m_k : m_tgt);
      if (m_k == m_tgt + 1) ed[m_owner] = 1'b1;
    end
    chk("model_gnt", bus.gnt, eg);
    chk("model_busy", bus.busy, m_busy);
    chk("model_count", bus.count, ec);
    chk("model_done", bus.done, ed);
  end

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    bus.abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_count(input int val, output bit seen_done);
    int n = 0;
    seen_done = 1'b0;
    while (bus.count != CW'(val) && n < 100) begin
      tick();
      n++;
      if (bus.done != '0) seen_done = 1'b1;
    end
    chk("reach_count", bus.count, val);
  endtask

  initial begin
    int n, done_at, hi, dn, cyc;
    bit sd;
    int order[$];
    int times[$];
    logic [NR-1:0] prev;
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};

    bus.req = '1;
    bus.len = {NR{8'd5}};
    bus.abort = 1'b0;

    // Reset held with all requests high.
    repeat (5) begin
      @(negedge clk);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_done", bus.done, 0);
    end
    rst = 1'b0;
    tick();
    chk("first_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    repeat (3) tick();

    // Single run, len 10 on requester 2.
    do_reset();
    bus.len[2*CW +: CW] = 8'd10;
    bus.req = 4'b0100;
    n = 0; done_at = -1;
    do begin
      tick();
      n++;
      if (n == 1) begin
        chk("single_gnt", bus.gnt, 4'b0100);
        chk("single_cnt0", bus.count, 0);
      end
      if (bus.done[2]) begin
        done_at = n;
        chk("single_done_cnt", bus.count, 10);
      end
    end while (bus.gnt != '0 && n < 40);
    bus.req = '0;
    chk("single_release", n, 13);
    chk("single_done_at", done_at, 12);

    // Round robin with 1011 held.
    do_reset();
    bus.len = {NR{8'd3}};
    bus.req = 4'b1011;
    prev = '0; cyc = 0;
    while (order.size() < 6 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.gnt != '0 && prev == '0) begin
        order.push_back(onehot_idx(bus.gnt));
        times.push_back(cyc);
      end
      prev = bus.gnt;
    end
    bus.req = '0;
    chk("rr_grants", order.size(), 6);
    for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], exp_order[i]);
    if (times.size() > 1) chk("rr_period", times[1] - times[0], 6);

    // Zero length on requester 1.
    do_reset();
    bus.len[1*CW +: CW] = 8'd0;
    bus.req = 4'b0010;
    hi = 0; dn = 0; done_at = -1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (bus.gnt != '0) hi++;
      if (bus.done[1]) begin dn++; done_at = i; end
    end
    bus.req = '0;
    chk("zero_gnt_cycles", hi, 2);
    chk("zero_done_count", dn, 1);
    chk("zero_done_at", done_at, 2);

    // Abort at count 5, then withdraw at count 7.
    do_reset();
    bus.len[0 +: CW] = 8'd20;
    @(negedge clk);
    bus.req = 4'b0001;
    wait_count(5, sd);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.req = '0;
    chk("abort_gnt", bus.gnt, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_count", bus.count, 0);
    chk("abort_nodone", {31'd0, sd} | 32'(bus.done), 0);
    @(negedge clk);
    bus.req = 4'b0001;
    wait_count(7, sd);
    bus.req = '0;
    tick();
    chk("wd_gnt", bus.gnt, 0);
    chk("wd_count", bus.count, 0);
    chk("wd_nodone", {31'd0, sd} | 32'(bus.done), 0);

    // Asynchronous reset mid-run.
    do_reset();
    bus.len[3*CW +: CW] = 8'd50;
    bus.req = 4'b1000;
    wait_count(12, sd);
    #3 rst = 1'b1;
    #1;
    chk("arst_gnt", bus.gnt, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_done", {31'd0, sd} | 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;

    // Random traffic; the compare process checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
        if ($urandom_range(5) == 0)
          bus.len[i*CW +: CW] = ($urandom_range(59) == 0) ? 8'd255 : CW'($urandom_range(12));
      end
      bus.abort = ($urandom_range(29) == 0);
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_share_arb.md
# timer_share_arb

Round-robin arbiter and sequencer that shares one up-counter timer among N_REQ requesters. Each requester asks for a timed interval of programmable length. The block grants the counter to one requester at a time, runs it from 0 to the requested length, and pulses that requester's done flag. It sits between the 50 MHz system-clock control logic and the shared free-running counter resource, replacing ad-hoc counter ownership.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 8, counter and length width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  level request per requester; held until done or withdrawn
- len  in  N_REQ*CNT_W  requested interval, requester i at bits [i*CNT_W +: CNT_W]; sampled only at grant
- abort  in  1  synchronous global cancel of the current run
- gnt  out  N_REQ  one-hot owner of the counter; all zero when idle
- done  out  N_REQ  one-cycle completion pulse to the owner
- busy  out  1  counter owned (RUN or DONE)
- count  out  CNT_W  current counter value

## Operation
- States:
  - IDLE: gnt=0, busy=0, count=0.
  - RUN: gnt is one-hot, busy=1, count advances.
  - DONE: gnt is held, busy=1, done[owner]=1, count holds at target.
- IDLE → RUN when any req bit is 1.
  - The winner is the first set req bit searching upward from last_owner+1, wrapping modulo N_REQ.
  - On that edge: latch target=len[winner], count<=0, gnt<=onehot(winner), last_owner<=winner.
- RUN, count<target: count<=count+1.
- RUN, count==target: → DONE. len=0 is legal and gives one RUN cycle.
- DONE → IDLE unconditionally. count<=0, gnt<=0. There is always at least one IDLE cycle between grants.
- Withdraw: in RUN, if req[owner]==0 or abort==1, go → IDLE next edge. count<=0, gnt<=0, no done pulse. Abort has priority over the count==target transition. In DONE, abort is ignored.
- abort in IDLE has no effect, and arbitration still occurs that cycle.
- len changes after grant are ignored. Only the latched target is used.
- Arithmetic is unsigned CNT_W. count never exceeds target, so no wrap occurs. target=2^CNT_W-1 is legal.
- Reset (async, any state): state=IDLE, gnt=0, done=0, busy=0, count=0, target=0, last_owner=N_REQ-1, so requester 0 has first priority. A reset during RUN drops the grant immediately, with no done pulse.

## Timing
- All outputs are registered, with no combinational paths from inputs to outputs.
- req sampled high in IDLE at edge T gives:
  - gnt, busy = 1 from T+1.
  - count = k at T+1+k.
  - done at T+2+len.
  - gnt=0 and busy=0 at T+3+len.
- The owner must keep req high through the DONE cycle. A drop during DONE has no effect.
- Back-to-back: a requester re-asserting req (or holding it high) is eligible in the IDLE cycle at T+3+len. Because of rotation, it wins only if no other requester is pending.
- Minimum period between successive grants is len+3 cycles.

## Test plan
- Reset hold: rst=1 for 100 ns with req=4'b1111 → gnt=0, busy=0, count=0, done=0 throughout. After release, the first grant goes to requester 0.
- Single run: req[2]=1 with len[2]=10 → gnt=4'b0100 one cycle later, count steps 0..10, done[2] one cycle after count==10, gnt clears the next cycle. Total 13 cycles from sampling to release.
- Round robin: req=4'b1011 held, all len=3 → grant order 0,1,3,0,1,3. Each grant lasts 5 cycles plus 1 IDLE cycle. Requester 2 is never granted.
- Zero length: len[1]=0, req[1]=1 → one RUN cycle with count=0, then done[1], then IDLE. gnt is high for 2 cycles.
- Abort/withdraw: len[0]=20, assert abort when count=5 → IDLE next cycle, count=0, no done pulse. Repeat with req[0] dropped at count=7 → same result.
- Async reset mid-run: len[3]=50, assert rst at count=12 between clock edges → gnt, busy and count clear immediately without waiting for a clock edge, and no done pulse occurs.
